alu_uart_if: RTL

Byte-level front end that sits directly upstream of the ALU and feeds it operands and opcode. It collects three consecutive bytes from the UART receiver (operand A, operand B, opcode), holds them stable on the ALU inputs, and hands the ALU result to the UART transmitter. It then waits for the transmission to finish before accepting a new frame.

---
 rtl/alu_if_pkg.sv | 22 ++
 rtl/alu_if_timer.sv | 30 +++
 rtl/alu_uart_if.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_if_pkg.sv
// Shared types and constants for the ALU UART front end: FSM state encoding
// and the opcode values the downstream ALU understands.
package alu_if_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_NOR = 8'h27;

endpackage

// File: rtl/alu_if_timer.sv
// Clearable inter-byte counter; expire is high during the cycle the count
// sits at TIMEOUT_CYCLES-1 while running.
module alu_if_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign expire = run && !clear && (count == LAST);

endmodule

// File: rtl/alu_uart_if.sv
// Collects A, B and opcode bytes from the UART receiver, presents them to the
// ALU and sends the result back. Define ALU_IF_TIMEOUT_EN for the inter-byte timeout.
module alu_uart_if
    import alu_if_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] alu_w,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_op,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              timeout
);

    state_t state;
    logic   expire;

`ifdef ALU_IF_TIMEOUT_EN
    // Counting only while a frame is partially received; sitting in WAIT_A keeps it cleared.
    alu_if_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    ((state == ST_WAIT_B) || (state == ST_WAIT_OP)),
        .clear  (rx_done || (state == ST_WAIT_A)),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT_A;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                ST_WAIT_A: begin
                    if (rx_done) begin
                        alu_a <= rx_data;
                        state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (rx_done) begin
                        alu_b <= rx_data;
                        state <= ST_WAIT_OP;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        state   <= ST_WAIT_A;
                    end
                end
                ST_WAIT_OP: begin
                    if (rx_done) begin
                        alu_op <= rx_data;
                        state  <= ST_SEND;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        state   <= ST_WAIT_A;
                    end
                end
                // alu_w has had a full cycle to settle on the new operands.
                ST_SEND: begin
                    tx_data  <= alu_w;
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        state <= ST_WAIT_A;
                    end
                end
                default: state <= ST_WAIT_A;
            endcase
        end
    end

    assign busy = (state == ST_SEND) || (state == ST_WAIT_TX);

endmodule
